// File: rtl/seg7_display_ctrl_pkg.sv
// seg7_pkg: shared constants, converter states and helpers for the 7-segment controller
package seg7_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

    typedef enum logic [1:0] {
        IDLE,
        CONVERT,
        COMMIT
    } conv_state_t;

    // Active-low {g,f,e,d,c,b,a} glyphs; non-decimal codes show nothing
    function automatic logic [6:0] glyph(input logic [3:0] d);
        case (d)
            4'd0:    return 7'h40;
            4'd1:    return 7'h79;
            4'd2:    return 7'h24;
            4'd3:    return 7'h30;
            4'd4:    return 7'h19;
            4'd5:    return 7'h12;
            4'd6:    return 7'h02;
            4'd7:    return 7'h78;
            4'd8:    return 7'h00;
            4'd9:    return 7'h10;
            default: return SEG_BLANK;
        endcase
    endfunction

    // Every 3 binary bits need at most one more BCD nibble
    function automatic int nbcd(input int width);
        return (width + 2) / 3;
    endfunction

endpackage

// File: rtl/seg7_display_ctrl_if.sv
// seg7_display_ctrl_if: valid/ready value handshake into the display controller
interface seg7_display_ctrl_if #(
    parameter int BIN_WIDTH = 16
);

    logic [BIN_WIDTH-1:0] value_in;
    logic                 value_valid;
    logic                 value_ready;

    modport master (output value_in, value_valid, input value_ready);
    modport slave  (input value_in, value_valid, output value_ready);

endinterface

// File: rtl/seg7_display_ctrl_bin2bcd.sv
// bin2bcd_seq: sequential double-dabble, one input bit per cycle, MSB first
module bin2bcd_seq
    import seg7_pkg::*;
#(
    parameter  int BIN_WIDTH = 16,
    localparam int NBCD      = nbcd(BIN_WIDTH)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [BIN_WIDTH-1:0] din,
    output logic                 busy,
    output logic                 done,
    output logic [4*NBCD-1:0]    bcd
);

    localparam int CW = $clog2(BIN_WIDTH);

    conv_state_t          state, state_next;
    logic [BIN_WIDTH-1:0] shreg;
    logic [CW-1:0]        cnt;
    logic [4*NBCD-1:0]    bcd_adj;

    // converter state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // next state; done marks the single cycle in which bcd holds the finished result
    always_comb begin
        state_next = state;
        busy       = 1'b1;
        done       = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) state_next = CONVERT;
            end
            CONVERT: if (cnt == CW'(BIN_WIDTH - 1)) state_next = COMMIT;
            COMMIT: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // add 3 to every nibble of 5 or more ahead of the shift
    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < NBCD; i++)
            if (bcd[4*i+:4] >= 4'd5) bcd_adj[4*i+:4] = bcd[4*i+:4] + 4'd3;
    end

    // capture on accept, then shift corrected BCD and binary together
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shreg <= '0;
            cnt   <= '0;
            bcd   <= '0;
        end else if (state == IDLE && start) begin
            shreg <= din;
            cnt   <= '0;
            bcd   <= '0;
        end else if (state == CONVERT) begin
            bcd   <= {bcd_adj[4*NBCD-2:0], shreg[BIN_WIDTH-1]};
            shreg <= shreg << 1;
            cnt   <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/seg7_display_ctrl.sv
// seg7_display_ctrl: handshaked BCD conversion, atomic display buffer and PWM digit scan
module seg7_display_ctrl
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS   = 8,
    parameter int BIN_WIDTH    = 16,
    parameter int REFRESH_DIV  = 100000,
    parameter int BRIGHT_WIDTH = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    seg7_display_ctrl_if.slave      bus,
    input  logic                    blank_lz,
    input  logic [NUM_DIGITS-1:0]   dp_mask,
    input  logic [BRIGHT_WIDTH-1:0] brightness,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    overflow
);

    localparam int NBCD = nbcd(BIN_WIDTH);
    localparam int PW   = $clog2(REFRESH_DIV);
    localparam int IW   = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;

    logic                                busy, done;
    logic [4*NBCD-1:0]                   bcd;
    logic [4*(NBCD+NUM_DIGITS)-1:0]      bcd_ext;
    logic [4*NUM_DIGITS-1:0]             buffer;
    logic [NUM_DIGITS-1:0]               lz_mask, lz_next;
    logic                                all_zero;
    logic [PW-1:0]                       presc;
    logic [IW-1:0]                       idx;
    logic [3:0]                          nib;
    logic                                blanked, lit;
    logic [6:0]                          seg_next;
    logic [NUM_DIGITS-1:0]               an_next;

    bin2bcd_seq #(.BIN_WIDTH(BIN_WIDTH)) u_conv (
        .clk   (clk),
        .reset (reset),
        .start (bus.value_valid),
        .din   (bus.value_in),
        .busy  (busy),
        .done  (done),
        .bcd   (bcd)
    );

    assign bus.value_ready = !busy;
    // zero-extend so short conversions fill all digits and the overflow slice always exists
    assign bcd_ext = {{4*NUM_DIGITS{1'b0}}, bcd};

    // digit i is a leading zero when it and every digit above it are zero; digit 0 never is
    always_comb begin
        lz_next  = '0;
        all_zero = 1'b1;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            all_zero   = all_zero && bcd_ext[4*i+:4] == 4'd0;
            lz_next[i] = all_zero;
        end
    end

    // commit the finished conversion atomically; the reset buffer is a zero with leading zeros marked
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            buffer   <= '0;
            lz_mask  <= ~NUM_DIGITS'(1);
            overflow <= 1'b0;
        end else if (done) begin
            buffer   <= bcd_ext[4*NUM_DIGITS-1:0];
            lz_mask  <= lz_next;
            overflow <= |bcd_ext[4*(NBCD+NUM_DIGITS)-1:4*NUM_DIGITS];
        end
    end

    // slot prescaler and digit index
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc <= '0;
            idx   <= '0;
        end else if (presc == PW'(REFRESH_DIV - 1)) begin
            presc <= '0;
            idx   <= idx == IW'(NUM_DIGITS - 1) ? '0 : idx + 1'b1;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    assign nib      = buffer[4*idx+:4];
    assign blanked  = !overflow && blank_lz && lz_mask[idx];
    assign lit      = presc != '0 && presc[BRIGHT_WIDTH-1:0] <= brightness && (!blanked || dp_mask[idx]);
    assign seg_next = overflow ? SEG_DASH : blanked ? SEG_BLANK : glyph(nib);
    assign an_next  = lit ? ~(NUM_DIGITS'(1) << idx) : '1;

    // registered pin drivers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seg <= SEG_BLANK;
            dp  <= 1'b1;
            an  <= '1;
        end else begin
            seg <= seg_next;
            dp  <= !dp_mask[idx];
            an  <= an_next;
        end
    end

endmodule

// File: tb/tb_seg7_display_ctrl.sv
// tb_seg7_display_ctrl: randomized display checks against a decimal-arithmetic reference model
module tb_seg7_display_ctrl;

    localparam int ND  = 3;
    localparam int BW  = 12;
    localparam int RD  = 32;
    localparam int BRW = 4;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           blank_lz = 1'b0;
    logic [ND-1:0]  dp_mask = '0;
    logic [BRW-1:0] brightness = '1;
    logic [6:0]     seg;
    logic           dp;
    logic [ND-1:0]  an;
    logic           overflow;
    int             checks = 0;
    int             errors = 0;
    int             cyc = 0;
    logic [6:0]     glyphs [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    seg7_display_ctrl_if #(.BIN_WIDTH(BW)) bus ();

    seg7_display_ctrl #(
        .NUM_DIGITS   (ND),
        .BIN_WIDTH    (BW),
        .REFRESH_DIV  (RD),
        .BRIGHT_WIDTH (BRW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .blank_lz   (blank_lz),
        .dp_mask    (dp_mask),
        .brightness (brightness),
        .seg        (seg),
        .dp         (dp),
        .an         (an),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    // clock edges since reset release; outputs after edge k show scan time k-1
    always @(posedge clk or posedge reset) cyc <= reset ? 0 : cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // expected {seg, dp, an} for displayed value v at scan time s
    function automatic logic [7+ND:0] model(input int v, input int s);
        int         p = s % RD;
        int         d = (s / RD) % ND;
        int         pw = 10 ** d;
        bit         ovf = v > 10 ** ND - 1;
        bit         blank = !ovf && blank_lz && d > 0 && v < pw;
        bit         on = p != 0 && (p % (1 << BRW)) <= int'(brightness) && (!blank || dp_mask[d]);
        logic [6:0] s_e = ovf ? 7'h3F : blank ? 7'h7F : glyphs[(v / pw) % 10];
        logic [ND-1:0] a_e = on ? ~(ND'(1) << d) : '1;
        return {s_e, !dp_mask[d], a_e};
    endfunction

    task automatic scan(input string tag, input int v);
        @(negedge clk);
        check({tag, "_ovf"}, 32'(overflow), 32'(v > 10 ** ND - 1));
        repeat (ND * RD) begin
            @(negedge clk);
            check(tag, 32'({seg, dp, an}), 32'(model(v, cyc - 1)));
        end
    endtask

    task automatic offer(input int v, input bit intrude);
        int k = 0;
        @(negedge clk);
        bus.value_in    = BW'(v);
        bus.value_valid = 1'b1;
        check("ready_idle", 32'(bus.value_ready), 32'd1);
        @(negedge clk);
        bus.value_valid = 1'b0;
        check("ready_drop", 32'(bus.value_ready), 32'd0);
        while (!bus.value_ready && k < 100) begin
            k++;
            bus.value_in    = intrude && k == 3 ? BW'(v ^ 12'h5A5) : BW'(v);
            bus.value_valid = intrude && k == 3;
            @(negedge clk);
        end
        bus.value_valid = 1'b0;
        check("ready_latency", 32'(k), 32'(BW + 1));
    endtask

    task automatic duty(input int bright, input int exp);
        int n = 0;
        brightness = BRW'(bright);
        @(negedge clk);
        repeat (ND * RD) begin
            @(negedge clk);
            if (an != '1) n++;
        end
        check("duty", 32'(n), 32'(exp));
    endtask

    initial begin
        bus.value_in    = '0;
        bus.value_valid = 1'b0;
        #23;
        check("rst_seg", 32'(seg), 32'h7F);
        check("rst_dp", 32'(dp), 32'd1);
        check("rst_an", 32'(an), 32'(7));
        check("rst_ready", 32'(bus.value_ready), 32'd1);
        check("rst_ovf", 32'(overflow), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        scan("zero", 0);
        blank_lz = 1'b1;
        scan("zero_lz", 0);
        blank_lz = 1'b0;
        offer(359, 1'b0);
        scan("v359", 359);
        blank_lz = 1'b1;
        offer(0, 1'b0);
        scan("v0_lz", 0);
        offer(42, 1'b0);
        scan("v42_lz", 42);
        dp_mask = 3'b100;
        scan("v42_dp", 42);
        dp_mask = '0;
        offer(1000, 1'b0);
        scan("v1000", 1000);
        offer(999, 1'b0);
        scan("v999", 999);
        blank_lz = 1'b0;
        offer(359, 1'b0);
        duty(0, ND);
        duty(15, ND * (RD - 1));
        offer(777, 1'b1);
        scan("intrude", 777);
        offer(1000, 1'b0);
        @(negedge clk);
        bus.value_in    = BW'(123);
        bus.value_valid = 1'b1;
        @(negedge clk);
        bus.value_valid = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        #1;
        check("mid_seg", 32'(seg), 32'h7F);
        check("mid_dp", 32'(dp), 32'd1);
        check("mid_an", 32'(an), 32'(7));
        check("mid_ready", 32'(bus.value_ready), 32'd1);
        check("mid_ovf", 32'(overflow), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        scan("after_rst", 0);
        for (int i = 0; i < 12; i++) begin
            int v = $urandom_range(0, 7) == 0 ? int'($urandom_range(1000, 4095)) : int'($urandom_range(0, 999));
            blank_lz   = 1'($urandom_range(0, 1));
            dp_mask    = ND'($urandom);
            brightness = BRW'($urandom);
            offer(v, 1'($urandom_range(0, 1)));
            scan("rand", v);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
